ahb_ap_resp_fifo: RTL and testbench

//   Response buffer directly downstream of the AHB access point. Stores 32-bit AHB read

---
 rtl/ahb_ap_resp_fifo_if.sv | 29 ++
 rtl/ahb_ap_resp_fifo.sv | 139 +++++++++++++
 tb/tb_ahb_ap_resp_fifo.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_ap_resp_fifo_if.sv
// Handshake bundle between the AHB access point, the response FIFO and the JTAG DR capture path.
// The master side pushes/pops; the slave side is the FIFO itself.
interface ahb_ap_resp_fifo_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              winc;
    logic [DATA_W-1:0] wdata;
    logic              capture_req;
    logic              clear;
    logic [DATA_W+1:0] resp;
    logic              rempty;
    logic              wfull;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output winc, wdata, capture_req, clear,
        input  resp, rempty, wfull, count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, capture_req, clear,
        output resp, rempty, wfull, count, overflow, underflow
    );
endinterface

// File: rtl/ahb_ap_resp_fifo.sv
// Response buffer behind the AHB access point: circular word store with sticky overflow/underflow
// status and a registered {valid, overflow, data} response loaded on each capture request.
//
//   state      | meaning
//   -----------+-------------------------------------------
//   ST_EMPTY   | no words buffered (count = 0)
//   ST_PARTIAL | some words buffered (0 < count < DEPTH)
//   ST_FULL    | every slot occupied (count = DEPTH)
module ahb_ap_resp_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input logic               AFT_CLK,
    input logic               nRST,
    ahb_ap_resp_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [DATA_W+1:0] resp_q, resp_d;

    logic [PW-1:0]     occ;
    logic              rempty;
    logic              wfull;
    logic              push_ok;
    logic              push_drop;
    logic              pop_ok;
    logic              pop_empty;

    always_ff @(posedge AFT_CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Full/empty are judged on the pre-cycle state, so a push while full is dropped even if a pop
    // frees a slot in the same cycle.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_ok) state_d = ST_PARTIAL;
                end
                ST_PARTIAL: begin
                    if (push_ok && !pop_ok && (occ == PW'(DEPTH - 1))) state_d = ST_FULL;
                    else if (pop_ok && !push_ok && (occ == PW'(1))) state_d = ST_EMPTY;
                end
                ST_FULL: begin
                    if (pop_ok) state_d = ST_PARTIAL;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        rempty = (state_q == ST_EMPTY);
        wfull  = (state_q == ST_FULL);
    end

    always_comb begin
        occ       = wptr_q - rptr_q;
        push_ok   = bus.winc & ~wfull & ~bus.clear;
        push_drop = bus.winc & wfull & ~bus.clear;
        pop_ok    = bus.capture_req & ~rempty & ~bus.clear;
        pop_empty = bus.capture_req & rempty & ~bus.clear;
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        resp_d      = resp_q;
        if (bus.clear) begin
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            resp_d      = '0;
        end else begin
            if (push_ok)   wptr_d     = wptr_q + PW'(1);
            if (push_drop) overflow_d = 1'b1;
            // Response carries the overflow flag as it stood before this cycle's push.
            if (pop_ok) begin
                rptr_d = rptr_q + PW'(1);
                resp_d = {1'b1, overflow_q, mem[rptr_q[AW-1:0]]};
            end else if (pop_empty) begin
                underflow_d = 1'b1;
                resp_d      = {1'b0, overflow_q, {DATA_W{1'b0}}};
            end
        end
    end

    always_ff @(posedge AFT_CLK or negedge nRST) begin
        if (!nRST) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            resp_q      <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            resp_q      <= resp_d;
        end
    end

    always_ff @(posedge AFT_CLK) begin
        if (push_ok) mem[wptr_q[AW-1:0]] <= bus.wdata;
    end

    assign bus.resp      = resp_q;
    assign bus.rempty    = rempty;
    assign bus.wfull     = wfull;
    assign bus.count     = occ;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_ahb_ap_resp_fifo.sv
// Self-checking bench for ahb_ap_resp_fifo: directed scenarios plus randomized traffic compared
// against a queue-based model of the buffer, sticky flags and registered response.
module tb_ahb_ap_resp_fifo;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic AFT_CLK = 1'b0;
    logic nRST    = 1'b0;
    always #5 AFT_CLK = ~AFT_CLK;

    ahb_ap_resp_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    ahb_ap_resp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .AFT_CLK (AFT_CLK),
        .nRST    (nRST),
        .bus     (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] mq[$];
    logic              m_ovf;
    logic              m_unf;
    logic [DATA_W+1:0] m_resp;

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_resp = '0;
    endtask

    // Drive one clock of stimulus, then advance the model with the same rules.
    task automatic cycle(input logic w, input logic [DATA_W-1:0] d, input logic c, input logic clr);
        bit                was_full, was_empty, ovf_pre;
        logic [DATA_W-1:0] word;
        bus.winc        = w;
        bus.wdata       = d;
        bus.capture_req = c;
        bus.clear       = clr;
        @(posedge AFT_CLK);
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        ovf_pre   = m_ovf;
        if (clr) begin
            model_reset();
        end else begin
            if (c) begin
                if (was_empty) begin
                    m_resp = {1'b0, ovf_pre, {DATA_W{1'b0}}};
                    m_unf  = 1'b1;
                end else begin
                    word   = mq.pop_front();
                    m_resp = {1'b1, ovf_pre, word};
                end
            end
            if (w) begin
                if (was_full) m_ovf = 1'b1;
                else mq.push_back(d);
            end
        end
        #1;
        bus.winc        = 1'b0;
        bus.capture_req = 1'b0;
        bus.clear       = 1'b0;
    endtask

    // Flag decode from the FSM must always agree with occupancy and with the model.
    always @(negedge AFT_CLK) begin
        if (nRST) begin
            checks++;
            if (bus.count !== CW'(mq.size())) begin
                failures++;
                $display("FAIL count_track got=%0d exp=%0d", bus.count, mq.size());
            end
            checks++;
            if ((bus.rempty !== (bus.count == 0)) || (bus.rempty !== (mq.size() == 0))) begin
                failures++;
                $display("FAIL rempty_equiv got=%b count=%0d exp_size=%0d", bus.rempty, bus.count, mq.size());
            end
            checks++;
            if ((bus.wfull !== (bus.count == CW'(DEPTH))) || (bus.wfull !== (mq.size() == DEPTH))) begin
                failures++;
                $display("FAIL wfull_equiv got=%b count=%0d exp_size=%0d", bus.wfull, bus.count, mq.size());
            end
        end
    end

    task automatic test_reset();
        checks++;
        if ({bus.resp, bus.count, bus.rempty, bus.wfull, bus.overflow, bus.underflow}
            !== {{(DATA_W+2){1'b0}}, {CW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state resp=%h count=%0d rempty=%b wfull=%b ovf=%b unf=%b exp resp=0 count=0 rempty=1 others=0",
                     bus.resp, bus.count, bus.rempty, bus.wfull, bus.overflow, bus.underflow);
        end
    endtask

    task automatic test_basic();
        logic [DATA_W+1:0] exp_r;
        for (int i = 1; i <= 3; i++) cycle(1'b1, 32'hDEAD0000 + 32'(i), 1'b0, 1'b0);
        checks++;
        if (bus.count !== CW'(3)) begin
            failures++;
            $display("FAIL basic_count3 got=%0d exp=3", bus.count);
        end
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            exp_r = {2'b10, 32'hDEAD0000 + 32'(i)};
            checks++;
            if (bus.resp !== exp_r) begin
                failures++;
                $display("FAIL basic_resp%0d got=%h exp=%h", i, bus.resp, exp_r);
            end
        end
        checks++;
        if (bus.count !== '0 || bus.rempty !== 1'b1) begin
            failures++;
            $display("FAIL basic_drained count=%0d rempty=%b exp count=0 rempty=1", bus.count, bus.rempty);
        end
        cycle(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (bus.resp !== {2'b10, 32'hDEAD0003}) begin
            failures++;
            $display("FAIL basic_hold got=%h exp=%h", bus.resp, {2'b10, 32'hDEAD0003});
        end
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] words[9];
        for (int i = 0; i < 9; i++) begin
            words[i] = $urandom;
            cycle(1'b1, words[i], 1'b0, 1'b0);
            checks++;
            if (bus.wfull !== (i >= 7)) begin
                failures++;
                $display("FAIL ovf_wfull_after_%0d got=%b exp=%b", i + 1, bus.wfull, (i >= 7));
            end
        end
        checks++;
        if (bus.overflow !== 1'b1 || bus.count !== CW'(DEPTH)) begin
            failures++;
            $display("FAIL ovf_flag ovf=%b count=%0d exp ovf=1 count=%0d", bus.overflow, bus.count, DEPTH);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (bus.resp !== {2'b11, words[i]} || bus.resp !== m_resp) begin
                failures++;
                $display("FAIL ovf_drain%0d got=%h exp=%h", i, bus.resp, {2'b11, words[i]});
            end
        end
    endtask

    task automatic test_underflow();
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (bus.resp !== '0 || bus.underflow !== 1'b1 || bus.overflow !== 1'b0 || bus.count !== '0) begin
            failures++;
            $display("FAIL underflow resp=%h unf=%b ovf=%b count=%0d exp resp=0 unf=1 ovf=0 count=0",
                     bus.resp, bus.underflow, bus.overflow, bus.count);
        end
    endtask

    task automatic test_simultaneous();
        logic [DATA_W-1:0] oldest, nw;
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        oldest = mq[0];
        nw     = $urandom;
        cycle(1'b1, nw, 1'b1, 1'b0);
        checks++;
        if (bus.resp !== {2'b10, oldest} || bus.overflow !== 1'b1 || bus.count !== CW'(7)) begin
            failures++;
            $display("FAIL full_push_pop resp=%h ovf=%b count=%0d exp resp=%h ovf=1 count=7",
                     bus.resp, bus.overflow, bus.count, {2'b10, oldest});
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, $urandom, 1'b1, 1'b0);
        checks++;
        if (bus.count !== CW'(4) || bus.resp !== m_resp) begin
            failures++;
            $display("FAIL mid_push_pop count=%0d resp=%h exp count=4 resp=%h", bus.count, bus.resp, m_resp);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (bus.resp !== m_resp) begin
                failures++;
                $display("FAIL mid_order%0d got=%h exp=%h", i, bus.resp, m_resp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] d;
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            d = 32'(i) * 32'h11111111;
            cycle(1'b1, d, 1'b0, 1'b0);
            cycle(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (bus.resp !== {2'b10, d}) begin
                failures++;
                $display("FAIL wrap%0d got=%h exp=%h", i, bus.resp, {2'b10, d});
            end
        end
        checks++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.rempty !== 1'b1) begin
            failures++;
            $display("FAIL wrap_flags ovf=%b unf=%b rempty=%b exp 0 0 1", bus.overflow, bus.underflow, bus.rempty);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (bus.count !== CW'(5) || bus.overflow !== 1'b1) begin
            failures++;
            $display("FAIL clear_setup count=%0d ovf=%b exp count=5 ovf=1", bus.count, bus.overflow);
        end
        cycle(1'b1, $urandom, 1'b1, 1'b1);
        checks++;
        if (bus.count !== '0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.resp !== '0) begin
            failures++;
            $display("FAIL clear count=%0d ovf=%b unf=%b resp=%h exp all 0",
                     bus.count, bus.overflow, bus.underflow, bus.resp);
        end
    endtask

    task automatic test_random();
        int wbias;
        for (int i = 0; i < 400; i++) begin
            wbias = (i < 200) ? 6 : 3;
            cycle(($urandom_range(0, 9) < wbias), $urandom, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 60) == 0));
            checks++;
            if (bus.resp !== m_resp || bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
                failures++;
                $display("FAIL random%0d resp=%h ovf=%b unf=%b exp resp=%h ovf=%b unf=%b",
                         i, bus.resp, bus.overflow, bus.underflow, m_resp, m_ovf, m_unf);
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        cycle(1'b1, $urandom, 1'b1, 1'b0);
        #2;
        nRST = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.resp, bus.count, bus.rempty, bus.wfull, bus.overflow, bus.underflow}
            !== {{(DATA_W+2){1'b0}}, {CW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset resp=%h count=%0d rempty=%b wfull=%b ovf=%b unf=%b",
                     bus.resp, bus.count, bus.rempty, bus.wfull, bus.overflow, bus.underflow);
        end
        @(posedge AFT_CLK);
        #1;
        nRST = 1'b1;
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (bus.resp !== '0 || bus.underflow !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_empty resp=%h unf=%b exp resp=0 unf=1", bus.resp, bus.underflow);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.winc        = 1'b0;
        bus.wdata       = '0;
        bus.capture_req = 1'b0;
        bus.clear       = 1'b0;
        model_reset();
        repeat (2) @(posedge AFT_CLK);
        #1;
        test_reset();
        nRST = 1'b1;
        test_reset();
        test_basic();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_wrap();
        test_clear();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
